// File: rtl/axil_sram_responder_if.sv
// AXI4-Lite read/write channel bundle between a bus master and the SRAM responder.
`timescale 1ns/1ps
interface axil_sram_responder_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_sram_responder.sv
// AXI4-Lite SRAM responder: word-addressed memory behind independent read and
// write FSMs, each with a fixed parameterised response latency.
`timescale 1ns/1ps
module axil_sram_responder #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input logic                  clk,
    input logic                  rst,
    axil_sram_responder_if.slave bus
);
    localparam int         ADDR_W      = $clog2(DEPTH);
    localparam logic [3:0] RD_LAT_C    = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C    = 4'(WR_LAT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // Misaligned addresses are slave errors; aligned ones beyond the array are decode errors.
    function automatic logic [1:0] decode_resp(input logic [31:0] addr);
        logic [1:0] resp;
        if (addr[1:0] != 2'b00) begin
            resp = RESP_SLVERR;
        end else if ((addr >> (ADDR_W + 2)) != 32'd0) begin
            resp = RESP_DECERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

    function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] addr);
        return addr[ADDR_W+1:2];
    endfunction

    logic [31:0] mem [DEPTH];

    // Read channel state
    rd_state_t   rd_state_r;
    logic [3:0]  rd_cnt_r;
    logic [31:0] rd_addr_r;
    logic        arready_r;
    logic        rvalid_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;

    // Write channel state
    wr_state_t   wr_state_r;
    logic [3:0]  wr_cnt_r;
    logic        aw_got_r;
    logic        w_got_r;
    logic [31:0] awaddr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;
    logic        awready_r;
    logic        wready_r;
    logic        bvalid_r;
    logic [1:0]  bresp_r;

    // Combinational helpers
    logic        ar_hs_s;
    logic [31:0] rd_addr_s;
    logic [1:0]  rd_resp_s;
    logic [31:0] rd_word_s;
    logic        rd_sample_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic [31:0] wr_addr_s;
    logic [31:0] wr_data_s;
    logic [3:0]  wr_strb_s;
    logic        wr_both_s;
    logic        wr_commit_s;
    logic [1:0]  wr_resp_s;

    assign bus.arready = arready_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;
    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bresp   = bresp_r;

    // Read side: pick the address to decode and decide on which edge the SRAM is sampled.
    always_comb begin
        ar_hs_s = bus.arvalid & arready_r;
        if (rd_state_r == R_IDLE) begin
            rd_addr_s = bus.araddr;
        end else begin
            rd_addr_s = rd_addr_r;
        end
        rd_resp_s = decode_resp(rd_addr_s);
        if (rd_resp_s == RESP_OKAY) begin
            rd_word_s = mem[word_index(rd_addr_s)];
        end else begin
            rd_word_s = 32'd0;
        end
        if (rd_state_r == R_IDLE) begin
            rd_sample_s = ar_hs_s & (RD_LAT_C == 4'd0);
        end else if (rd_state_r == R_WAIT) begin
            rd_sample_s = (rd_cnt_r == 4'd1);
        end else begin
            rd_sample_s = 1'b0;
        end
    end

    // Write side: merge captured and live AW/W fields and find the commit edge.
    always_comb begin
        aw_hs_s = bus.awvalid & awready_r;
        w_hs_s  = bus.wvalid & wready_r;
        if (aw_got_r) begin
            wr_addr_s = awaddr_r;
        end else begin
            wr_addr_s = bus.awaddr;
        end
        if (w_got_r) begin
            wr_data_s = wdata_r;
            wr_strb_s = wstrb_r;
        end else begin
            wr_data_s = bus.wdata;
            wr_strb_s = bus.wstrb;
        end
        if (wr_state_r == W_IDLE) begin
            wr_both_s   = (aw_got_r | aw_hs_s) & (w_got_r | w_hs_s);
            wr_commit_s = wr_both_s & (WR_LAT_C == 4'd0);
        end else if (wr_state_r == W_WAIT) begin
            wr_both_s   = 1'b0;
            wr_commit_s = (wr_cnt_r == 4'd1);
        end else begin
            wr_both_s   = 1'b0;
            wr_commit_s = 1'b0;
        end
        wr_resp_s = decode_resp(wr_addr_s);
    end

    // Byte-masked SRAM write on the edge bvalid rises; a concurrent read sees the old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit_s && (wr_resp_s == RESP_OKAY)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_s[b]) begin
                    mem[word_index(wr_addr_s)][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: accept AR, wait RD_LAT cycles, present data until the master takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= R_IDLE;
            rd_cnt_r   <= 4'd0;
            rd_addr_r  <= 32'd0;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'd0;
            rresp_r    <= RESP_OKAY;
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rd_addr_r  <= bus.araddr;
                        arready_r  <= 1'b0;
                        rd_cnt_r   <= RD_LAT_C;
                        rd_state_r <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    rd_cnt_r <= rd_cnt_r - 4'd1;
                end
                R_RESP: begin
                    if (rvalid_r && bus.rready) begin
                        rvalid_r   <= 1'b0;
                        arready_r  <= 1'b1;
                        rd_state_r <= R_IDLE;
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    arready_r  <= 1'b1;
                    rvalid_r   <= 1'b0;
                end
            endcase
            if (rd_sample_s) begin
                rd_state_r <= R_RESP;
                rvalid_r   <= 1'b1;
                rdata_r    <= rd_word_s;
                rresp_r    <= rd_resp_s;
            end
        end
    end

    // Write FSM: capture AW and W in any order, wait WR_LAT cycles, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_r <= W_IDLE;
            wr_cnt_r   <= 4'd0;
            aw_got_r   <= 1'b0;
            w_got_r    <= 1'b0;
            awaddr_r   <= 32'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            bvalid_r   <= 1'b0;
            bresp_r    <= RESP_OKAY;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        awaddr_r  <= bus.awaddr;
                        aw_got_r  <= 1'b1;
                        awready_r <= 1'b0;
                    end
                    if (w_hs_s) begin
                        wdata_r  <= bus.wdata;
                        wstrb_r  <= bus.wstrb;
                        w_got_r  <= 1'b1;
                        wready_r <= 1'b0;
                    end
                    if (wr_both_s) begin
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b0;
                        wr_cnt_r   <= WR_LAT_C;
                        wr_state_r <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    wr_cnt_r <= wr_cnt_r - 4'd1;
                end
                W_RESP: begin
                    if (bvalid_r && bus.bready) begin
                        bvalid_r   <= 1'b0;
                        awready_r  <= 1'b1;
                        wready_r   <= 1'b1;
                        aw_got_r   <= 1'b0;
                        w_got_r    <= 1'b0;
                        wr_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    awready_r  <= 1'b1;
                    wready_r   <= 1'b1;
                    aw_got_r   <= 1'b0;
                    w_got_r    <= 1'b0;
                    bvalid_r   <= 1'b0;
                end
            endcase
            if (wr_commit_s) begin
                wr_state_r <= W_RESP;
                bvalid_r   <= 1'b1;
                bresp_r    <= wr_resp_s;
            end
        end
    end
endmodule
